// File: rtl/axis_lane_unpacker.sv
// AXI4-Stream 8x16 -> 8x12 lane unpacker with a 2-entry (output + skid) buffer.
// Optional saturation and sticky per-lane overflow flags under `LANE_SAT_EN.

module axis_lane_unpacker_lane #(
  parameter int IN_SHIFT = 0
) (
  input  logic [15:0] lane_i,
  output logic [11:0] smp_o,
  output logic        ovf_o
);
  logic signed [16:0] v;
  assign v = $signed({lane_i[15], lane_i}) >>> IN_SHIFT;

`ifdef LANE_SAT_EN
  always_comb begin
    smp_o = v[11:0];
    ovf_o = 1'b0;
    if (v > 17'sd2047) begin
      smp_o = 12'h7FF;
      ovf_o = 1'b1;
    end else if (v < -17'sd2048) begin
      smp_o = 12'h800;
      ovf_o = 1'b1;
    end
  end
`else
  logic [4:0] unused_hi;
  assign unused_hi = v[16:12];
  assign smp_o     = v[11:0];
  assign ovf_o     = 1'b0;
`endif
endmodule

module axis_lane_unpacker #(
  parameter int IN_SHIFT = 0,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [127:0]      s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [95:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [7:0]        ovf_o,
  input  logic              ovf_clr_i,
  output logic [CNT_W-1:0]  beat_cnt_o
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [95:0]      out_q, out_d, skid_q, skid_d;
  logic             rdy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [95:0]      nar;
  logic [7:0]       lane_ovf;
  logic             acc, otx;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    axis_lane_unpacker_lane #(.IN_SHIFT(IN_SHIFT)) u_lane (
      .lane_i (s_axis_tdata[16*i +: 16]),
      .smp_o  (nar[12*i +: 12]),
      .ovf_o  (lane_ovf[i])
    );
  end

  assign acc = s_axis_tvalid && rdy_q;
  assign otx = (state_q != ST_EMPTY) && m_axis_tready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: if (acc) begin
        state_d = ST_ONE;
        out_d   = nar;
      end
      ST_ONE: begin
        if (acc && otx) out_d = nar;
        else if (acc) begin
          state_d = ST_FULL;
          skid_d  = nar;
        end else if (otx) state_d = ST_EMPTY;
      end
      ST_FULL: if (otx) begin
        state_d = ST_ONE;
        out_d   = skid_q;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Ready is registered from the next state, so it is already low while FULL.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != ST_FULL);
      if (acc) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef LANE_SAT_EN
  logic [7:0] ovf_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          ovf_q <= '0;
    else if (ovf_clr_i) ovf_q <= '0;
    else if (acc)       ovf_q <= ovf_q | lane_ovf;
  end
  assign ovf_o = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{lane_ovf, ovf_clr_i};
  assign ovf_o      = '0;
`endif

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = (state_q != ST_EMPTY);
  assign m_axis_tdata  = out_q;
  assign beat_cnt_o    = cnt_q;
endmodule

// File: tb/tb_axis_lane_unpacker.sv
// Self-checking bench for axis_lane_unpacker: vector table, hand sequences and a
// queue-based reference model under random valid/ready traffic.
module tb_axis_lane_unpacker;
  logic         clk = 0;
  logic         rst;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid, s_axis_tready;
  logic [95:0]  m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready;
  logic [7:0]   ovf_o;
  logic         ovf_clr;
  logic [31:0]  beat_cnt_o;

  logic [127:0] s2_tdata;
  logic         s2_tvalid, s2_tready;
  logic [95:0]  m2_tdata;
  logic         m2_tvalid;
  logic [7:0]   ovf2;
  logic [2:0]   cnt2;

  always #5 clk = ~clk;

  axis_lane_unpacker #(.IN_SHIFT(0), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .ovf_o(ovf_o), .ovf_clr_i(ovf_clr), .beat_cnt_o(beat_cnt_o));

  axis_lane_unpacker #(.IN_SHIFT(2), .CNT_W(3)) dut2 (
    .clk_i(clk), .rst_i(rst), .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid),
    .s_axis_tready(s2_tready), .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid),
    .m_axis_tready(1'b1), .ovf_o(ovf2), .ovf_clr_i(1'b0), .beat_cnt_o(cnt2));

  int n_chk = 0, n_fail = 0;
  logic [95:0] q[$];
  int cnt_m = 0, n_out = 0;
  logic [7:0] ovf_m = '0;
  bit fresh = 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference lane: signed divide-by-2^sh (floor), then clamp or keep low 12 bits.
  function automatic logic [12:0] ref_lane(input logic [15:0] l, input int sh);
    int v;
    logic [12:0] r;
    v = int'($signed(l)) >>> sh;
    r = {1'b0, v[11:0]};
`ifdef LANE_SAT_EN
    if (v > 2047)       r = {1'b1, 12'h7FF};
    else if (v < -2048) r = {1'b1, 12'h800};
`endif
    return r;
  endfunction

  function automatic logic [95:0] ref_beat(input logic [127:0] d, input int sh);
    logic [95:0] b;
    logic [12:0] r;
    for (int i = 0; i < 8; i++) begin
      r = ref_lane(d[16*i +: 16], sh);
      b[12*i +: 12] = r[11:0];
    end
    return b;
  endfunction

  function automatic logic [7:0] ref_ovf(input logic [127:0] d);
    logic [7:0] o;
    logic [12:0] r;
    for (int i = 0; i < 8; i++) begin
      r = ref_lane(d[16*i +: 16], 0);
      o[i] = r[12];
    end
    return o;
  endfunction

  // One clock of traffic on dut; inputs are set by the caller at the preceding negedge.
  task automatic step();
    logic acc, otx;
    logic [95:0] nb;
    logic [7:0] no;
    acc = s_axis_tvalid && s_axis_tready;
    otx = m_axis_tvalid && m_axis_tready;
    nb  = ref_beat(s_axis_tdata, 0);
    no  = ref_ovf(s_axis_tdata);
    chk("m_tvalid", 128'(m_axis_tvalid), 128'(q.size() > 0));
    chk("s_tready", 128'(s_axis_tready), 128'((q.size() < 2) && !fresh));
    if (otx && q.size() > 0) chk("m_tdata", 128'(m_axis_tdata), 128'(q[0]));
    @(posedge clk);
    fresh = 0;
    if (otx && q.size() > 0) begin void'(q.pop_front()); n_out++; end
    if (acc) begin q.push_back(nb); cnt_m++; end
    if (ovf_clr) ovf_m = '0;
    else if (acc) ovf_m = ovf_m | no;
    @(negedge clk);
    chk("beat_cnt", 128'(beat_cnt_o), 128'(cnt_m));
    chk("ovf", 128'(ovf_o), 128'(ovf_m));
  endtask

  typedef struct {
    logic [127:0] din;
    logic [95:0]  dout;
    logic [7:0]   ovf;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [127:0] d;
    int acc_n, first_out, last_out, out0, cnt0;

    tbl[0] = '{128'h0, 96'h0, 8'h00};
    tbl[1] = '{128'h03E8 << 48, 96'h3E8 << 36, 8'h00};
    tbl[2] = '{128'hFC18, 96'hC18, 8'h00};
    tbl[3] = '{{8{16'h03E8}}, {8{12'h3E8}}, 8'h00};
`ifdef LANE_SAT_EN
    tbl[4] = '{128'h0900 << 80, 96'h7FF << 60, 8'h20};
    tbl[5] = '{128'hF000 << 80, 96'h800 << 60, 8'h20};
`else
    tbl[4] = '{128'h0900 << 80, 96'h900 << 60, 8'h00};
    tbl[5] = '{128'hF000 << 80, 96'h000, 8'h00};
`endif

    rst = 1; s_axis_tdata = '0; s_axis_tvalid = 0; m_axis_tready = 1; ovf_clr = 0;
    s2_tdata = '0; s2_tvalid = 0;
    repeat (2) @(negedge clk);
    chk("rst m_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst m_tdata", 128'(m_axis_tdata), 128'(0));
    chk("rst s_tready", 128'(s_axis_tready), 128'(0));
    chk("rst ovf", 128'(ovf_o), 128'(0));
    chk("rst cnt", 128'(beat_cnt_o), 128'(0));
    rst = 0;
    step();

    // Vector table: accept one beat, check it one cycle later, then drain.
    for (int k = 0; k < 6; k++) begin
      s_axis_tdata = tbl[k].din; s_axis_tvalid = 1;
      step();
      s_axis_tvalid = 0;
      chk($sformatf("tbl%0d data", k), 128'(m_axis_tdata), 128'(tbl[k].dout));
      chk($sformatf("tbl%0d ovf", k), 128'(ovf_o), 128'(tbl[k].ovf));
      step();
    end
    ovf_clr = 1; step(); ovf_clr = 0;
    chk("ovf after clr", 128'(ovf_o), 128'(0));
    // Clear wins over a same-cycle overflowing beat.
    s_axis_tdata = 128'h0900 << 80; s_axis_tvalid = 1; ovf_clr = 1;
    step();
    s_axis_tvalid = 0; ovf_clr = 0;
    chk("clr prio", 128'(ovf_o), 128'(0));
    step();

    // Backpressure: beats 1..5 while downstream stalls for 4 cycles.
    acc_n = 0; first_out = -1; last_out = -1; out0 = n_out; cnt0 = cnt_m;
    for (int cyc = 0; cyc < 30; cyc++) begin
      m_axis_tready = (cyc >= 4);
      s_axis_tvalid = (acc_n < 5);
      s_axis_tdata  = {8{16'(acc_n + 1)}};
      if (cyc == 2) begin
        chk("bp accepted", 128'(acc_n), 128'(2));
        chk("bp s_tready low", 128'(s_axis_tready), 128'(0));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (s_axis_tvalid && s_axis_tready) acc_n++;
      step();
    end
    s_axis_tvalid = 0; m_axis_tready = 1;
    chk("bp outputs", 128'(n_out - out0), 128'(5));
    chk("bp no gaps", 128'(last_out - first_out), 128'(4));
    chk("bp cnt", 128'(beat_cnt_o), 128'(cnt0 + 5));

    // Random traffic against the queue model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 5))
          0: d[16*i +: 16] = 16'h07FF;
          1: d[16*i +: 16] = 16'hF800;
          2: d[16*i +: 16] = 16'h0800;
          default: d[16*i +: 16] = 16'($urandom);
        endcase
      end
      s_axis_tdata  = d;
      s_axis_tvalid = ($urandom_range(0, 9) < 7);
      m_axis_tready = ($urandom_range(0, 9) < 6);
      ovf_clr       = ($urandom_range(0, 19) == 0);
      step();
    end
    s_axis_tvalid = 0; ovf_clr = 0; m_axis_tready = 1;
    repeat (3) step();

    // IN_SHIFT=2 instance with a 3-bit wrapping counter.
    s2_tvalid = 1;
    for (int k = 0; k < 12; k++) begin
      if (k == 0)      d = {8{16'h0FA0}};
      else if (k == 1) d = {8{16'hF060}};
      else             d = {$urandom, $urandom, $urandom, $urandom};
      s2_tdata = d;
      @(posedge clk); @(negedge clk);
      chk("sh2 data", 128'(m2_tdata), 128'(ref_beat(d, 2)));
      chk("sh2 cnt wrap", 128'(cnt2), 128'((k + 1) % 8));
      if (k == 0) chk("sh2 0FA0", 128'(m2_tdata), 128'({8{12'h3E8}}));
      if (k == 1) chk("sh2 F060", 128'(m2_tdata), 128'({8{12'hC18}}));
    end
    s2_tvalid = 0;

    // Reset while FULL.
    m_axis_tready = 0; s_axis_tvalid = 1; s_axis_tdata = {8{16'h0123}};
    for (int k = 0; k < 4 && q.size() < 2; k++) step();
    chk("pre-rst full", 128'(q.size()), 128'(2));
    rst = 1;
    #1;
    chk("async m_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("async s_tready", 128'(s_axis_tready), 128'(0));
    chk("async m_tdata", 128'(m_axis_tdata), 128'(0));
    q.delete(); cnt_m = 0; ovf_m = '0; fresh = 1;
    s_axis_tvalid = 0; m_axis_tready = 1;
    @(posedge clk); @(negedge clk);
    rst = 0;
    step();
    s_axis_tdata = {8{16'h0042}}; s_axis_tvalid = 1;
    step();
    s_axis_tvalid = 0;
    chk("post-rst data", 128'(m_axis_tdata), 128'({8{12'h042}}));
    step();
    chk("post-rst drained", 128'(m_axis_tvalid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
